// File: rtl/variable_step_unit_pkg.sv
// Shared constants and FSM encoding for the adaptive step-size controller.
package variable_step_unit_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned FRAC_W = 32;
  localparam int unsigned N_MAX  = 50;

  localparam logic [ADDR_W-1:0] N_ADDR   = 11'd0;
  localparam logic [ADDR_W-1:0] T1_ADDR  = 11'd1;
  localparam logic [ADDR_W-1:0] T2_ADDR  = 11'd2;
  localparam logic [ADDR_W-1:0] H_ADDR   = 11'd17;
  localparam logic [ADDR_W-1:0] TOL_ADDR = 11'd18;
  localparam logic [ADDR_W-1:0] X0_BASE  = 11'd119;
  localparam logic [ADDR_W-1:0] X1_BASE  = 11'd169;

  localparam logic signed [DATA_W-1:0] Q_MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Q_MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] Q_LSB     = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic signed [DATA_W-1:0] Q_ONE     = Q_LSB <<< FRAC_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_N,
    ST_LD_T1,
    ST_LD_T2,
    ST_LD_H,
    ST_LD_TOL,
    ST_WAIT_ERR,
    ST_RD_X0,
    ST_RD_X1,
    ST_ACC,
    ST_DECIDE,
    ST_WRITE,
    ST_DONE
  } vsu_state_e;

endpackage

// File: rtl/variable_step_unit_ram.sv
// 2^AW x DW working RAM: synchronous write, registered read (1-cycle latency).
// Contents are deliberately not reset.
module vs_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] Mem [0:(1<<AW)-1];

  // Single-port array with read-before-write output register.
  always_ff @(posedge clk) begin
    if (i_we) begin
      Mem[i_addr] <= i_wdata;
    end
    o_rdata <= Mem[i_addr];
  end

endmodule

// File: rtl/variable_step_unit.sv
// Adaptive step-size controller: loads solver parameters from its working RAM,
// measures the infinity-norm error between X0 and X1, accepts/rejects the step
// and writes the adjusted step size h back to H_ADDR.
module variable_step_unit
  import variable_step_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start_cal_err,
  output logic [ADDR_W-1:0] address_bus,
  output logic [DATA_W-1:0] data_bus,
  output logic              mem_wr_enable,
  output logic              error_ok,
  output logic              h_done
);

  vsu_state_e r_state, w_next;

  logic [DATA_W-1:0]        r_n;
  logic signed [DATA_W-1:0] r_t1, r_t2, r_h, r_tol, r_x0, r_err_max, r_h_new;
  logic [5:0]               r_i;
  logic                     r_error_ok;
  logic                     r_tol_pend;
  logic                     r_start_q, r_start_qq;

  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_rdata;
  logic                     w_we;
  logic                     w_start_edge;
  logic [5:0]               w_neff;
  logic signed [DATA_W-1:0] w_diff, w_abs, w_err_next;
  logic                     w_accept, w_grow;
  logic signed [DATA_W-1:0] w_h_dbl, w_h_half, w_h_shrink, w_h_cand, w_span, w_h_new;

  assign w_start_edge = r_start_q & ~r_start_qq;
  assign w_neff       = (r_n > 64'(N_MAX)) ? 6'(N_MAX) : r_n[5:0];
  assign w_we         = (r_state == ST_WRITE);

  vs_ram #(.AW(ADDR_W), .DW(DATA_W)) RAM (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_addr),
    .i_wdata (r_h_new),
    .o_rdata (w_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; enable low forces IDLE from any state.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_next = ST_LD_N;
        ST_LD_N:     w_next = ST_LD_T1;
        ST_LD_T1:    w_next = ST_LD_T2;
        ST_LD_T2:    w_next = ST_LD_H;
        ST_LD_H:     w_next = ST_LD_TOL;
        ST_LD_TOL:   w_next = ST_WAIT_ERR;
        ST_WAIT_ERR: if (w_start_edge) w_next = (w_neff == 6'd0) ? ST_DECIDE : ST_RD_X0;
        ST_RD_X0:    w_next = ST_RD_X1;
        ST_RD_X1:    w_next = ST_ACC;
        ST_ACC:      w_next = ((r_i + 6'd1) >= w_neff) ? ST_DECIDE : ST_RD_X0;
        ST_DECIDE:   w_next = ST_WRITE;
        ST_WRITE:    w_next = ST_DONE;
        ST_DONE:     w_next = ST_WAIT_ERR;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  // RAM address per state; idle-like states park at 0.
  always_comb begin
    w_addr = '0;
    case (r_state)
      ST_LD_N:   w_addr = N_ADDR;
      ST_LD_T1:  w_addr = T1_ADDR;
      ST_LD_T2:  w_addr = T2_ADDR;
      ST_LD_H:   w_addr = H_ADDR;
      ST_LD_TOL: w_addr = TOL_ADDR;
      ST_RD_X0:  w_addr = X0_BASE + {5'b0, r_i};
      ST_RD_X1:  w_addr = X1_BASE + {5'b0, r_i};
      ST_WRITE:  w_addr = H_ADDR;
      default:   w_addr = '0;
    endcase
  end

  // |X0[i]-X1[i]| with the most-negative difference saturated, then running max.
  always_comb begin
    w_diff     = r_x0 - $signed(w_rdata);
    w_abs      = w_diff;
    if (w_diff == Q_MIN_NEG) begin
      w_abs = Q_MAX_POS;
    end else if (w_diff[DATA_W-1]) begin
      w_abs = -w_diff;
    end
    w_err_next = (w_abs > r_err_max) ? w_abs : r_err_max;
  end

  // Accept/reject decision and new step size with saturation and span clamp.
  always_comb begin
    w_accept   = (r_err_max <= r_tol);
    w_grow     = (r_err_max < (r_tol >>> 2));
    w_h_dbl    = r_h <<< 1;
    if (r_h[DATA_W-1] != r_h[DATA_W-2]) begin
      w_h_dbl = r_h[DATA_W-1] ? Q_MIN_NEG : Q_MAX_POS;
    end
    w_h_half   = r_h >>> 1;
    w_h_shrink = (w_h_half == '0) ? Q_LSB : w_h_half;
    if (w_accept) begin
      w_h_cand = w_grow ? w_h_dbl : r_h;
    end else begin
      w_h_cand = w_h_shrink;
    end
    w_span  = r_t2 - r_t1;
    w_h_new = ((r_t2 > r_t1) && (w_h_cand > w_span)) ? w_span : w_h_cand;
  end

  // Datapath registers: parameter capture, error accumulation, decision.
  // Read data lags the address by one cycle, so each LD_* state captures the
  // word addressed by the previous state; tol arrives in the first WAIT_ERR
  // cycle and is captured through r_tol_pend.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_n        <= '0;
      r_t1       <= '0;
      r_t2       <= '0;
      r_h        <= '0;
      r_tol      <= '0;
      r_x0       <= '0;
      r_err_max  <= '0;
      r_h_new    <= '0;
      r_i        <= '0;
      r_error_ok <= 1'b0;
      r_tol_pend <= 1'b0;
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
    end else begin
      r_start_q  <= start_cal_err;
      r_start_qq <= r_start_q;
      r_tol_pend <= (r_state == ST_LD_TOL);
      if (r_tol_pend) begin
        r_tol <= $signed(w_rdata);
      end
      case (r_state)
        ST_LD_T1:  r_n  <= w_rdata;
        ST_LD_T2:  r_t1 <= $signed(w_rdata);
        ST_LD_H:   r_t2 <= $signed(w_rdata);
        ST_LD_TOL: r_h  <= $signed(w_rdata);
        ST_WAIT_ERR: begin
          if (enable && w_start_edge) begin
            r_err_max  <= '0;
            r_error_ok <= 1'b0;
            r_i        <= '0;
          end
        end
        ST_RD_X1:  r_x0 <= $signed(w_rdata);
        ST_ACC: begin
          r_err_max <= w_err_next;
          r_i       <= r_i + 6'd1;
        end
        ST_DECIDE: begin
          if (enable) begin
            r_error_ok <= w_accept;
            r_h_new    <= w_h_new;
          end
        end
        ST_WRITE:  r_h <= r_h_new;
        default: ;
      endcase
    end
  end

  // Bus outputs decoded from the current state.
  always_comb begin
    address_bus   = w_addr;
    mem_wr_enable = (r_state == ST_WRITE);
    h_done        = (r_state == ST_DONE);
    error_ok      = r_error_ok;
    data_bus      = w_rdata;
    if (r_state == ST_WRITE) begin
      data_bus = r_h_new;
    end else if (r_state == ST_IDLE) begin
      data_bus = '0;
    end
  end

endmodule

// File: tb/tb_variable_step_unit.sv
// Scoreboard bench for variable_step_unit: RAM is preloaded hierarchically,
// expected results come from a small reference model of the step rules.
module tb_variable_step_unit;
  import variable_step_unit_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              start_cal_err;
  logic [ADDR_W-1:0] address_bus;
  logic [DATA_W-1:0] data_bus;
  logic              mem_wr_enable;
  logic              error_ok;
  logic              h_done;

  variable_step_unit dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start_cal_err (start_cal_err),
    .address_bus   (address_bus),
    .data_bus      (data_bus),
    .mem_wr_enable (mem_wr_enable),
    .error_ok      (error_ok),
    .h_done        (h_done)
  );

  always #5 clk = ~clk;

  localparam logic signed [63:0] H01   = 64'h0000_0000_1999_999A; // 0.1
  localparam logic signed [63:0] H08   = 64'h0000_0000_CCCC_CCCD; // 0.8
  localparam logic signed [63:0] TOL02 = 64'h0000_0000_051E_B852; // 0.02
  localparam logic signed [63:0] D001  = 64'd42949673;            // 0.01
  localparam logic signed [63:0] D005  = 64'd214748365;           // 0.05

  typedef struct {
    logic        ok;
    logic [63:0] h;
    int unsigned lat;
    int unsigned nx0;
  } exp_t;

  exp_t sb_q[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  longint             m_n;
  logic signed [63:0] m_t1, m_t2, m_h, m_tol;
  logic signed [63:0] m_x0 [60];
  logic signed [63:0] m_x1 [60];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_base();
    m_n   = 3;
    m_t1  = Q_ONE;
    m_t2  = 2 * Q_ONE;
    m_h   = H01;
    m_tol = TOL02;
    for (int i = 0; i < 60; i++) begin
      m_x0[i] = 64'(i + 1) * Q_ONE;
      m_x1[i] = (i < 50) ? m_x0[i] : 64'sd0;
    end
  endtask

  task automatic write_mem();
    dut.RAM.Mem[N_ADDR]   = m_n;
    dut.RAM.Mem[T1_ADDR]  = m_t1;
    dut.RAM.Mem[T2_ADDR]  = m_t2;
    dut.RAM.Mem[H_ADDR]   = m_h;
    dut.RAM.Mem[TOL_ADDR] = m_tol;
    for (int i = 0; i < 50; i++) dut.RAM.Mem[X0_BASE + 11'(i)] = m_x0[i];
    for (int i = 0; i < 60; i++) dut.RAM.Mem[X1_BASE + 11'(i)] = m_x1[i];
  endtask

  function automatic exp_t model();
    exp_t               e;
    longint             neff;
    logic signed [63:0] err, d, a, nh, span;
    neff = (m_n > 50) ? 50 : m_n;
    err  = 0;
    for (int i = 0; i < neff; i++) begin
      d = m_x0[i] - m_x1[i];
      if (d == Q_MIN_NEG) a = Q_MAX_POS;
      else if (d < 0)     a = -d;
      else                a = d;
      if (a > err) err = a;
    end
    if (err <= m_tol) begin
      e.ok = 1'b1;
      if (err < (m_tol >>> 2)) nh = (m_h > Q_MAX_POS / 2) ? Q_MAX_POS : m_h * 2;
      else                     nh = m_h;
    end else begin
      e.ok = 1'b0;
      nh   = m_h >>> 1;
      if (nh == 0) nh = 1;
    end
    span = m_t2 - m_t1;
    if (m_t2 > m_t1 && nh > span) nh = span;
    e.h   = nh;
    e.lat = 32'(3 * neff + 3);
    e.nx0 = 32'(neff);
    return e;
  endfunction

  task automatic reload();
    @(negedge clk) enable = 1'b0;
    repeat (2) @(negedge clk);
    write_mem();
    enable = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_eval(input string tag);
    exp_t        o;
    int unsigned nwr   = 0;
    int unsigned nx0   = 0;
    int unsigned nover = 0;
    int unsigned lat   = 0;
    int unsigned extra = 0;
    logic        seen  = 1'b0;
    sb_q.push_back(model());
    @(negedge clk) start_cal_err = 1'b1;
    for (int unsigned c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 1) check_eq({tag, "_ok_clr"}, 64'(error_ok), 64'd0);
      if (address_bus >= X0_BASE && address_bus < X1_BASE) nx0++;
      if (address_bus >= X1_BASE + 11'd50 && address_bus < X1_BASE + 11'd60) nover++;
      if (mem_wr_enable) begin
        nwr++;
        check_eq({tag, "_wr_addr"}, 64'(address_bus), 64'(H_ADDR));
        check_eq({tag, "_wr_data"}, data_bus, sb_q[0].h);
      end
      if (h_done) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
    o = sb_q.pop_front();
    check_eq({tag, "_error_ok"}, 64'(error_ok), 64'(o.ok));
    check_eq({tag, "_mem_h"}, dut.RAM.Mem[H_ADDR], o.h);
    check_eq({tag, "_latency"}, 64'(lat), 64'(o.lat));
    check_eq({tag, "_wr_count"}, 64'(nwr), 64'd1);
    check_eq({tag, "_x0_reads"}, 64'(nx0), 64'(o.nx0));
    check_eq({tag, "_overrun"}, 64'(nover), 64'd0);
    // start still held high: must not retrigger
    repeat (6) begin
      @(posedge clk); #1;
      if (h_done || mem_wr_enable) extra++;
    end
    check_eq({tag, "_no_retrig"}, 64'(extra), 64'd0);
    check_eq({tag, "_ok_hold"}, 64'(error_ok), 64'(o.ok));
    @(negedge clk) start_cal_err = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_ok);
    check_eq({tag, "_addr"}, 64'(address_bus), 64'd0);
    check_eq({tag, "_data"}, data_bus, 64'd0);
    check_eq({tag, "_wr"}, 64'(mem_wr_enable), 64'd0);
    check_eq({tag, "_done"}, 64'(h_done), 64'd0);
    check_eq({tag, "_ok"}, 64'(error_ok), 64'(exp_ok));
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    start_cal_err = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);

    set_base();
    write_mem();
    reset = 1'b1;
    @(negedge clk) enable = 1'b1;
    repeat (8) @(negedge clk);

    // err=0 -> accept, h doubled
    run_eval("t_equal");
    check_eq("t_equal_const", dut.RAM.Mem[H_ADDR], 64'h0000_0000_3333_3334);

    // err=0.05 > tol -> reject, h halved
    set_base();
    m_x1[2] = m_x0[2] + D005;
    reload();
    run_eval("t_reject");
    check_eq("t_reject_const", dut.RAM.Mem[H_ADDR], 64'h0000_0000_0CCC_CCCD);

    // tol/4 < err=0.01 <= tol -> accept, h unchanged
    set_base();
    m_x1[1] = m_x0[1] + D001;
    reload();
    run_eval("t_keep");
    check_eq("t_keep_const", dut.RAM.Mem[H_ADDR], H01);

    // h=0.8 doubled to 1.6, clamped to t2-t1=1.0
    set_base();
    m_h = H08;
    reload();
    run_eval("t_clamp");
    check_eq("t_clamp_const", dut.RAM.Mem[H_ADDR], Q_ONE);

    // N=0 -> loop skipped
    set_base();
    m_n = 0;
    reload();
    run_eval("t_n0");

    // N=60 -> only 50 elements read
    set_base();
    m_n = 60;
    reload();
    run_eval("t_n60");

    // enable low while waiting: error_ok keeps the accepted value
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("en_wait", 1'b1);

    // enable low in the read loop, then recover
    set_base();
    reload();
    @(negedge clk) start_cal_err = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("en_abort", 1'b0);
    repeat (20) @(negedge clk);
    start_cal_err = 1'b0;
    check_eq("en_abort_mem", dut.RAM.Mem[H_ADDR], H01);
    m_x1[0] = m_x0[0] - D005;
    reload();
    run_eval("t_after_en");

    // reset in the read loop, then recover
    set_base();
    reload();
    @(negedge clk) start_cal_err = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_abort", 1'b0);
    repeat (20) @(negedge clk);
    start_cal_err = 1'b0;
    check_eq("rst_abort_mem", dut.RAM.Mem[H_ADDR], H01);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    run_eval("t_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
